// File: rtl/vector_rotator.sv
`default_nettype none
// ============================================================================
// Module   : vector_rotator
// Function : Rotates a Q-format 2-D vector by an integer angle in degrees
//            using external sine/cosine units, with timeout passthrough.
// Revision : 1.0
// ============================================================================
module vector_rotator #(
    parameter int FRAC_BITS = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] y_in,
    input  logic [8:0]         angle_in,
    output logic               trig_start_out,
    output logic [8:0]         trig_angle_out,
    input  logic signed [31:0] cos_in,
    input  logic signed [31:0] sin_in,
    input  logic               trig_done_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic signed [31:0] x_out,
    output logic signed [31:0] y_out,
    output logic               err_out
);

    localparam int                 CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic signed [64:0] SAT_HI  = 65'sh0_7FFF_FFFF;
    localparam logic signed [64:0] SAT_LO  = -65'sh0_8000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_MUL    = 3'd4,
        S_SUM    = 3'd5,
        S_OUT    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [31:0] x_q, x_d, y_q, y_d;
    logic [8:0]         angle_q, angle_d;
    logic signed [31:0] cos_q, cos_d, sin_q, sin_d;
    logic signed [63:0] p_xc_q, p_xc_d, p_ys_q, p_ys_d;
    logic signed [63:0] p_xs_q, p_xs_d, p_yc_q, p_yc_d;
    logic signed [31:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;

    logic signed [64:0] sum_x, sum_y;

    function automatic logic signed [63:0] sext64(input logic signed [31:0] v);
        sext64 = $signed({{32{v[31]}}, v});
    endfunction

    // Arithmetic shift floors toward -inf before clamping to 32-bit range.
    function automatic logic signed [31:0] sat_q(input logic signed [64:0] sum);
        logic signed [64:0] shifted;
        shifted = sum >>> FRAC_BITS;
        if (shifted > SAT_HI) begin
            sat_q = 32'sh7FFF_FFFF;
        end else if (shifted < SAT_LO) begin
            sat_q = 32'h8000_0000;
        end else begin
            sat_q = shifted[31:0];
        end
    endfunction

    always_comb begin
        sum_x = $signed({p_xc_q[63], p_xc_q}) - $signed({p_ys_q[63], p_ys_q});
        sum_y = $signed({p_xs_q[63], p_xs_q}) + $signed({p_yc_q[63], p_yc_q});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        angle_d = angle_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        p_xc_d  = p_xc_q;
        p_ys_d  = p_ys_q;
        p_xs_d  = p_xs_q;
        p_yc_d  = p_yc_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                // ready_q gates acceptance so nothing is taken on the first edge after reset.
                if (valid_in && ready_q) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    angle_d = (angle_in >= 9'd360) ? (angle_in - 9'd360) : angle_in;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // trig_done_in may still be high from the previous operation here.
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (trig_done_in) begin
                    cos_d   = cos_in;
                    sin_d   = sin_in;
                    state_d = S_MUL;
                end else if (cnt_q == CNT_MAX) begin
                    x_out_d = x_q;
                    y_out_d = y_q;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_MUL: begin
                p_xc_d  = sext64(x_q) * sext64(cos_q);
                p_ys_d  = sext64(y_q) * sext64(sin_q);
                p_xs_d  = sext64(x_q) * sext64(sin_q);
                p_yc_d  = sext64(y_q) * sext64(cos_q);
                state_d = S_SUM;
            end
            S_SUM: begin
                x_out_d = sat_q(sum_x);
                y_out_d = sat_q(sum_y);
                err_d   = 1'b0;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake/strobe outputs are registered from the next state.
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_OUT);
        start_d = (state_d == S_LAUNCH);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            angle_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            p_xc_q  <= '0;
            p_ys_q  <= '0;
            p_xs_q  <= '0;
            p_yc_q  <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            angle_q <= angle_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            p_xc_q  <= p_xc_d;
            p_ys_q  <= p_ys_d;
            p_xs_q  <= p_xs_d;
            p_yc_q  <= p_yc_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    assign ready_out      = ready_q;
    assign trig_start_out = start_q;
    assign trig_angle_out = angle_q;
    assign valid_out      = valid_q;
    assign x_out          = x_out_q;
    assign y_out          = y_out_q;
    assign err_out        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_rotator
// Function : Self-checking bench for vector_rotator with a trig-unit model.
// Revision : 1.0
// ============================================================================
module tb_vector_rotator;

    localparam int FRAC_BITS  = 16;
    localparam int TIMEOUT    = 1023;
    localparam int WAIT_START = 3;
    localparam int CYC_LIMIT  = 1100;

    logic               clk_in;
    logic               rst_n_in;
    logic               valid_in;
    logic               ready_out;
    logic signed [31:0] x_in;
    logic signed [31:0] y_in;
    logic [8:0]         angle_in;
    logic               trig_start_out;
    logic [8:0]         trig_angle_out;
    logic signed [31:0] cos_in;
    logic signed [31:0] sin_in;
    logic               trig_done_in;
    logic               valid_out;
    logic               ready_in;
    logic signed [31:0] x_out;
    logic signed [31:0] y_out;
    logic               err_out;

    int n_checks = 0;
    int n_pass   = 0;

    vector_rotator #(
        .FRAC_BITS (FRAC_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .x_in           (x_in),
        .y_in           (y_in),
        .angle_in       (angle_in),
        .trig_start_out (trig_start_out),
        .trig_angle_out (trig_angle_out),
        .cos_in         (cos_in),
        .sin_in         (sin_in),
        .trig_done_in   (trig_done_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .x_out          (x_out),
        .y_out          (y_out),
        .err_out        (err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // a*m (sub ? - : +) b*n, divided by 2^FRAC_BITS with floor, clamped to 32 bits.
    function automatic logic signed [31:0] rot_ref(input logic signed [31:0] a, input logic signed [31:0] b,
                                                   input logic signed [31:0] m, input logic signed [31:0] n,
                                                   input bit sub);
        logic signed [127:0] pa, pb, pm, pn, s, q, r, dv;
        pa = a; pb = b; pm = m; pn = n;
        dv = 128'sd1 << FRAC_BITS;
        s  = sub ? (pa * pm - pb * pn) : (pa * pm + pb * pn);
        q  = s / dv;
        r  = s % dv;
        if (s < 0 && r != 0) q = q - 1;
        if (q > 128'sd2147483647) return 32'sh7FFF_FFFF;
        if (q < -128'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

    // One transaction. lat: cycles after the start-pulse cycle at which the trig
    // model raises done (-1 = never). stale: done stays high from the last op
    // until WAIT begins. hold: cycles of ready_in=0 once the result is valid.
    task automatic run_txn(input logic signed [31:0] x, input logic signed [31:0] y,
                           input logic [8:0] ang, input logic signed [31:0] c,
                           input logic signed [31:0] s, input int lat, input int hold,
                           input bit stale);
        int cyc, d_cyc, exp_valid, got_valid, extra_start, hold_bad;
        bit exp_err;
        logic signed [31:0] exp_x, exp_y, hx, hy;
        logic he;
        logic [8:0] exp_ang;

        exp_ang = 9'(ang % 360);
        check_val("ready_idle", ready_out, 1);
        x_in = x; y_in = y; angle_in = ang; valid_in = 1'b1;
        ready_in = (hold == 0);
        @(negedge clk_in);
        check_val("start_pulse", trig_start_out, 1);
        check_val("trig_angle", trig_angle_out, exp_ang);
        check_val("ready_busy", ready_out, 0);
        x_in = $urandom; y_in = $urandom; angle_in = 9'($urandom);
        cos_in = $urandom; sin_in = $urandom;
        if (!stale) trig_done_in = 1'b0;

        cyc = 1; got_valid = 0; extra_start = 0;
        while (got_valid == 0 && cyc < CYC_LIMIT) begin
            @(negedge clk_in);
            cyc++;
            if (trig_start_out) extra_start++;
            if (valid_out) begin
                got_valid = cyc;
            end else begin
                if (cyc == WAIT_START) begin
                    check_val("angle_hold", trig_angle_out, exp_ang);
                    valid_in = 1'b0;
                    if (stale) trig_done_in = 1'b0;
                end
                if (lat >= 0 && cyc == 1 + lat) begin
                    trig_done_in = 1'b1; cos_in = c; sin_in = s;
                end
            end
        end

        if (lat >= 0 && 1 + lat <= WAIT_START + TIMEOUT) begin
            d_cyc     = (1 + lat < WAIT_START) ? WAIT_START : 1 + lat;
            exp_valid = d_cyc + 3;
            exp_err   = 1'b0;
            exp_x     = rot_ref(x, y, c, s, 1'b1);
            exp_y     = rot_ref(x, y, s, c, 1'b0);
        end else begin
            exp_valid = WAIT_START + TIMEOUT + 1;
            exp_err   = 1'b1;
            exp_x     = x;
            exp_y     = y;
        end
        check_val("valid_cycle", got_valid, exp_valid);
        check_val("x_out", $unsigned(x_out), $unsigned(exp_x));
        check_val("y_out", $unsigned(y_out), $unsigned(exp_y));
        check_val("err_out", err_out, exp_err);
        check_val("single_start", extra_start, 0);

        hx = x_out; hy = y_out; he = err_out; hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_in);
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || x_out !== hx ||
                y_out !== hy || err_out !== he) hold_bad++;
        end
        if (hold > 0) check_val("hold_stable", hold_bad, 0);
        ready_in = 1'b1;
        @(negedge clk_in);
        check_val("valid_drop", valid_out, 0);
        ready_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {ready_out, trig_start_out, trig_angle_out, valid_out, err_out}, 0);
        check_val(tag, {x_out, y_out}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [31:0] rx, ry, rc, rs;
        rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0; trig_done_in = 1'b0;
        x_in = '0; y_in = '0; angle_in = '0; cos_in = '0; sin_in = '0;

        #12;
        check_reset_outputs("reset_state");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check_val("ready_after_reset", ready_out, 1);

        // Directed cases from the rotation rules and boundaries.
        run_txn(32'sh0001_0000, 32'sh0, 9'd0,  32'sh0001_0000, 32'sh0, 20, 0, 1'b0);
        run_txn(32'sh0001_0000, 32'sh0002_0000, 9'd90, 32'sh0, 32'sh0001_0000, 5, 0, 1'b0);
        check_val("angle90_x", $unsigned(x_out), 32'hFFFE_0000);
        run_txn($urandom, $urandom, 9'd400, 32'sh0000_8000, 32'sh0000_4000, 4, 0, 1'b0);
        run_txn($urandom, $urandom, 9'd359, 32'sh0001_0000, 32'sh0, 1, 0, 1'b0);
        run_txn($urandom, $urandom, 9'd360, 32'sh0001_0000, 32'sh0, 2, 0, 1'b0);
        run_txn(32'sh7FFF_0000, 32'sh7FFF_0000, 9'd45, 32'sh0000_B505, 32'sh0000_B505, 6, 0, 1'b0);
        check_val("sat_y", $unsigned(y_out), 32'h7FFF_FFFF);
        run_txn(32'sh0003_0000, 32'sh0004_0000, 9'd10, 32'sh0, 32'sh0, -1, 0, 1'b1);
        run_txn(32'sh0005_0000, -32'sh0002_0000, 9'd30, 32'sh0000_DDB4, 32'sh0000_8000, 1025, 0, 1'b0);
        run_txn(32'sh0001_8000, 32'sh0000_4000, 9'd200, -32'sh0000_F0E4, -32'sh0000_5792, 7, 10, 1'b0);

        // Reset while waiting for the trig units.
        check_val("ready_idle", ready_out, 1);
        x_in = 32'sh0009_0000; y_in = 32'sh0001_0000; angle_in = 9'd77; valid_in = 1'b1; ready_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0; trig_done_in = 1'b0;
        repeat (8) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("reset_mid_op");
        @(negedge clk_in);
        trig_done_in = 1'b1;
        @(negedge clk_in);
        rst_n_in = 1'b1; ready_in = 1'b0;
        @(negedge clk_in);
        check_val("ready_after_abort", ready_out, 1);
        repeat (3) @(negedge clk_in);
        check_val("late_done_ignored", {valid_out, trig_start_out}, 0);
        run_txn(32'sh0002_0000, 32'sh0003_0000, 9'd180, -32'sh0001_0000, 32'sh0, 3, 0, 1'b0);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 16; t++) begin
            rx = $urandom;
            ry = $urandom;
            if (t % 4 == 3) begin
                rc = $urandom; rs = $urandom;
            end else begin
                rc = $signed($urandom_range(0, 32'h0002_0000)) - 32'sh0001_0000;
                rs = $signed($urandom_range(0, 32'h0002_0000)) - 32'sh0001_0000;
            end
            run_txn(rx, ry, 9'($urandom_range(0, 511)), rc, rs,
                    int'($urandom_range(1, 25)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_rotator.md
# vector_rotator

Rotates a 2-D fixed-point vector (Q16.16) by an integer angle in degrees. It sits directly downstream of the `sine`/`cosine` units. Per transaction it reduces the angle, pulses their shared `start`, waits for completion, then computes x' = x·cos − y·sin and y' = x·sin + y·cos. Results are returned through a valid/ready handshake to the scene-transform logic.

## Interface

Parameters:
- `FRAC_BITS`, default 16: fractional bits of all Q-format values, including trig amplitudes.
- `TIMEOUT`, default 1023: maximum cycles spent waiting for trig completion.

Ports (one clock; reset is asynchronous and active-low):
- `clk_in`, input, 1: system clock; all state changes on the rising edge.
- `rst_n_in`, input, 1: asynchronous active-low reset.
- `valid_in`, input, 1: request valid.
- `ready_out`, output, 1: block can accept a request.
- `x_in`, `y_in`, input, 32 signed: vector components, Q16.16.
- `angle_in`, input, 9: angle in degrees, 0–511 accepted.
- `trig_start_out`, output, 1: start pulse to the `sine`/`cosine` units.
- `trig_angle_out`, output, 9: reduced angle driven to the trig units' `value` port.
- `cos_in`, `sin_in`, input, 32 signed: trig `amp_out` values, Q16.16.
- `trig_done_in`, input, 1: both trig results valid (top level ANDs the two `done` signals).
- `valid_out`, output, 1: result valid.
- `ready_in`, input, 1: downstream accepts the result.
- `x_out`, `y_out`, output, 32 signed: rotated vector, Q16.16, saturated.
- `err_out`, output, 1: result is a timeout passthrough.

## Operation

States: IDLE → LAUNCH → SETTLE → WAIT → MUL → SUM → OUT → IDLE.
- **IDLE**
  - `ready_out`=1.
  - On `valid_in && ready_out`: latch `x_in` and `y_in`.
  - Latch the reduced angle: `angle_in` if < 360, else `angle_in` − 360.
  - Go to LAUNCH.
- **LAUNCH**
  - `trig_start_out`=1 for exactly this cycle.
  - `trig_angle_out` holds the latched reduced angle from LAUNCH through SUM.
- **SETTLE**
  - One cycle; `trig_done_in` is ignored, because `done` may still be high from the previous operation.
  - Clear the timeout counter.
- **WAIT**
  - On `trig_done_in`=1: capture `cos_in` and `sin_in`, then go to MUL.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to OUT with `x_out`/`y_out` = latched inputs and `err_out`=1.
- **MUL**: register the four signed 64-bit products x·cos, y·sin, x·sin and y·cos.
- **SUM**
  - Form 65-bit sums.
  - Arithmetic shift right by `FRAC_BITS` (truncation toward −∞).
  - Saturate to [0x80000000, 0x7FFFFFFF].
  - Register into `x_out`/`y_out`, with `err_out`=0.
- **OUT**
  - `valid_out`=1; `x_out`, `y_out` and `err_out` are held stable until `ready_in`=1.
  - Completes on the cycle `valid_out && ready_in`, then go to IDLE.
- `ready_out`=0 in every state except IDLE. Exactly one request is in flight; no queuing.

## Timing

- Reset (asynchronous assert, synchronous release):
  - state IDLE, counter 0.
  - `ready_out`=1 after the first edge following release (0 while reset is asserted).
  - `trig_start_out`=0, `trig_angle_out`=0, `valid_out`=0, `x_out`=0, `y_out`=0, `err_out`=0.
- Reset mid-operation aborts the transaction and returns everything to the reset values. A late `trig_done_in` afterwards is ignored because the block is in IDLE.
- Accept edge is cycle 0:
  - `trig_start_out` is high in cycle 1.
  - WAIT begins in cycle 3.
- If `trig_done_in` is first sampled high in WAIT at cycle D, `valid_out` rises at cycle D+3 (MUL, SUM, OUT).
- With immediate `ready_in`, the next accept is possible at D+4.
- Timeout: `valid_out` rises `TIMEOUT`+1 cycles after WAIT entry.
- `trig_done_in` high and the counter reaching `TIMEOUT` in the same cycle: done wins, and `err_out`=0.
- `ready_in` high before `valid_out`: no effect.
- `valid_in` held high while busy: ignored, and not latched.

## Test plan

- **Angle 0:** x=0x00010000, y=0. Bench trig model returns cos=0x00010000, sin=0, latency 20. Required: `x_out`=0x00010000, `y_out`=0, `err_out`=0, `valid_out` at D+3.
- **Angle 90:** x=0x00010000, y=0x00020000. Model returns cos=0, sin=0x00010000. Required: `x_out`=0xFFFE0000 (−2.0), `y_out`=0x00010000.
- **Reduction and start pulse:** `angle_in`=400. Required: `trig_angle_out`=40, `trig_start_out` high exactly one cycle. With `angle_in`=359 → 359; with 360 → 0.
- **Saturation:** x=y=0x7FFF0000, angle 45, cos=sin=0x0000B505. Required: `y_out`=0x7FFFFFFF; `x_out`=0 (the two products cancel exactly).
- **Timeout:** `trig_done_in` held 0, x=0x00030000, y=0x00040000. Required: `valid_out` after 1024 WAIT cycles, `err_out`=1, `x_out`=0x00030000, `y_out`=0x00040000. Additionally, `trig_done_in` stuck at 1 from the previous op is ignored during SETTLE.
- **Backpressure and reset:**
  - Hold `ready_in`=0 for 10 cycles: outputs stay stable and `ready_out`=0.
  - Assert `rst_n_in`=0 during WAIT: all outputs go to reset values immediately, and the next request completes normally.
